paired_drain_counter: RTL and testbench
=======================================

# paired_drain_counter

Consumer-side companion to the paired step-up accumulators. It accepts a loaded (x, y) pair through a valid/ready handshake and drains both registers in lockstep by a fixed STEP on each selector-enabled cycle. It stops and reports completion when another step would underflow either register. It sits in the simple-arithmetic property suite as a formal/bench target whose invariants are stated below.

## Interface
Parameters:
- WIDTH, 8, bit width of x, y, load_x, load_y
- STEP, 10, decrement applied to both registers per enabled cycle; 1 ≤ STEP < 2^WIDTH
- CNT_W, 8, width of the steps counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- load_valid  input  1  load request
- load_ready  output  1  high only in IDLE
- load_x  input  WIDTH  initial x, sampled on accepted load
- load_y  input  WIDTH  initial y, sampled on accepted load
- selector  input  1  drain enable
- x  output  WIDTH  x register
- y  output  WIDTH  y register
- busy  output  1  high in DRAIN
- done  output  1  one-cycle completion pulse, high in DONE
- underflow  output  1  registered; valid while done is high, held until next accepted load
- steps  output  CNT_W  count of decrements since last load, saturating

## Operation
- States: IDLE, DRAIN, DONE. Reset state: IDLE.
- Reset values:
  - x = 0, y = 0, steps = 0
  - underflow = 0, done = 0, busy = 0, load_ready = 1
- IDLE:
  - load_ready = 1.
  - On load_valid, capture x ← load_x, y ← load_y, steps ← 0 and underflow ← 0, then go to DRAIN.
  - selector is ignored in IDLE.
  - Without a load, x and y hold their last values.
- DRAIN:
  - load_ready = 0 and busy = 1. load_valid is ignored (no capture, no stall of the source beyond ready = 0).
  - selector = 0: hold all state.
  - selector = 1 with x ≥ STEP and y ≥ STEP:
    - x ← x − STEP, y ← y − STEP.
    - steps ← steps + 1, saturating at 2^CNT_W − 1.
    - Stay in DRAIN.
  - selector = 1 with x < STEP or y < STEP:
    - No subtraction.
    - underflow ← (x ≠ 0) || (y ≠ 0).
    - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - x, y, steps and underflow hold.
  - Unconditional transition to IDLE.
- Arithmetic: comparisons are unsigned at WIDTH bits. Subtraction never wraps, because it is guarded by the ≥ STEP check.
- Invariants, to be written as assertions in the RTL:
  - (x − y) mod 2^WIDTH is constant from an accepted load until the next accepted load.
  - x ≥ 0 and y ≥ 0 with no wrap.
  - done implies !busy.
  - load_ready == (state == IDLE).
  - Case example: after loading (30, 10), the pair (20, 0) is reachable and (20, 10) is not.

## Timing
- Load accept cycle T: the new x, y and busy = 1 are visible at T+1.
- First decrement: selector at T+1 → result at T+2. selector sampled at T itself has no effect.
- Decrement latency: 1 cycle from selector high to updated x, y and steps.
- Termination: selector high at cycle N with a guard failing → done = 1 and underflow valid at N+1. load_ready = 1 at N+2.
- Minimum cycle count for a full operation with k decrements: 1 (load) + k + 1 (terminating selector) + 1 (DONE).
- Reset mid-operation (any state): next cycle is IDLE with all reset values. No done pulse is generated.
- Simultaneous rst and load_valid: rst wins.

## Structure
- Shared package (arith_pkg): state enum typedef {IDLE, DRAIN, DONE} and the default STEP/WIDTH localparams. The same package is reused by the step-up accumulator.
- No sub-module is needed. If a split is wanted, a saturating counter sub-module sat_counter (parameter CNT_W, inputs inc/clr) is natural for steps.

## Test plan
- Load (20, 20), then selector high for 3 cycles:
  - x, y step (10, 10) → (0, 0).
  - Third selector → done = 1, underflow = 0, steps = 2.
- Load (30, 20), then selector high continuously:
  - (20, 10) → (10, 0).
  - Next selector → done = 1, underflow = 1, x = 10, y = 0, steps = 2.
- Load (25, 5), selector high → immediate done, underflow = 1, x = 25, y = 5, steps = 0.
- Load (40, 40) with selector toggling 1, 0, 0, 1:
  - Decrements only on high cycles: (30, 30) then (20, 20).
  - load_valid pulsed during DRAIN → ignored, load_ready = 0.
- Load (50, 50), two decrements, assert rst → next cycle x = 0, y = 0, IDLE, no done pulse. Then a load of (10, 0) is accepted normally.
- STEP = 1, WIDTH = 8, load (255, 255), selector held high:
  - steps saturates at 255 when x = y = 0.
  - Next selector → done, underflow = 0.
  - Invariant x − y = 0 holds throughout.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-suite package.
// Holds the controller state encoding and the default datapath sizing used by
// both the paired drain counter and the paired step-up accumulator.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_STEP  = 10;
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   clr   - synchronous clear (takes priority over inc)
//   inc   - increment request, ignored once count is all-ones
//   count - current count value
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/paired_drain_counter.sv
// Paired drain counter.
// Accepts an (x, y) pair through a valid/ready handshake, then decrements both
// registers by STEP on every selector-enabled cycle until another step would
// take either register below zero. Completion is signalled by a one-cycle done
// pulse; underflow reports whether any residue was left in x or y.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   load_valid/ready    - load handshake (ready only in IDLE)
//   load_x, load_y      - initial pair, sampled on an accepted load
//   selector            - drain enable, only honoured in DRAIN
//   x, y                - current register values
//   busy                - high in DRAIN
//   done                - one-cycle pulse in DONE
//   underflow           - residue flag, held until the next accepted load
//   steps               - saturating count of decrements since last load
module paired_drain_counter
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_x,
    input  logic [WIDTH-1:0] load_y,
    input  logic             selector,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [CNT_W-1:0] steps
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             underflow_q, underflow_d;

    logic             load_fire;
    logic             guard_ok;
    logic             dec_fire;

    // Both registers must be able to absorb a full STEP; this guard is what
    // keeps the subtraction from ever wrapping.
    assign guard_ok  = (x_q >= STEP_W) && (y_q >= STEP_W);
    assign load_fire = (state_q == IDLE) && load_valid;
    assign dec_fire  = (state_q == DRAIN) && selector && guard_ok;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        underflow_d = underflow_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    x_d         = load_x;
                    y_d         = load_y;
                    underflow_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (selector) begin
                    if (guard_ok) begin
                        x_d = x_q - STEP_W;
                        y_d = y_q - STEP_W;
                    end else begin
                        underflow_d = (x_q != '0) || (y_q != '0);
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            underflow_q <= underflow_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_steps (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_fire),
        .inc  (dec_fire),
        .count(steps)
    );

    assign x          = x_q;
    assign y          = y_q;
    assign underflow  = underflow_q;
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == DRAIN);
    assign done       = (state_q == DONE);

`ifndef SYNTHESIS
    // Lockstep draining preserves the difference between the two registers
    // everywhere except across a load or a reset.
    a_diff_const: assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && !$past(load_fire)) |-> ((x_q - y_q) == $past(x_q - y_q)));

    // A decrement never increases either register (no wrap-around).
    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        dec_fire |=> ((x_q <= $past(x_q)) && (y_q <= $past(y_q))));

    a_done_not_busy: assert property (@(posedge clk) done |-> !busy);

    a_ready_idle: assert property (@(posedge clk) load_ready == (state_q == IDLE));
`endif

endmodule

// File: tb/tb_paired_drain_counter.sv
module tb_paired_drain_counter;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_x;
    logic [7:0] load_y;
    logic       selector;

    // Default instance: WIDTH 8, STEP 10, CNT_W 8
    logic       load_ready;
    logic [7:0] x, y, steps;
    logic       busy, done, underflow;

    // STEP = 1 instance
    logic       load_ready1;
    logic [7:0] x1, y1, steps1;
    logic       busy1, done1, underflow1;

    // STEP = 1 with a narrow 4-bit steps counter (saturation check)
    logic       load_ready2;
    logic [7:0] x2, y2;
    logic [3:0] steps2;
    logic       busy2, done2, underflow2;

    int checks;
    int failures;

    paired_drain_counter #(.WIDTH(8), .STEP(10), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_x(load_x), .load_y(load_y), .selector(selector),
        .x(x), .y(y), .busy(busy), .done(done), .underflow(underflow), .steps(steps)
    );

    paired_drain_counter #(.WIDTH(8), .STEP(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
        .load_x(load_x), .load_y(load_y), .selector(selector),
        .x(x1), .y(y1), .busy(busy1), .done(done1), .underflow(underflow1), .steps(steps1)
    );

    paired_drain_counter #(.WIDTH(8), .STEP(1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready2),
        .load_x(load_x), .load_y(load_y), .selector(selector),
        .x(x2), .y(y2), .busy(busy2), .done(done2), .underflow(underflow2), .steps(steps2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full observation of the default instance against expected values.
    task automatic expect0(input string name, input logic [7:0] ex, input logic [7:0] ey,
                           input logic [7:0] es, input logic eb, input logic ed,
                           input logic eu, input logic er);
        checks++;
        if (x !== ex || y !== ey || steps !== es || busy !== eb || done !== ed ||
            underflow !== eu || load_ready !== er) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d steps=%0d busy=%b done=%b uf=%b rdy=%b, want x=%0d y=%0d steps=%0d busy=%b done=%b uf=%b rdy=%b",
                     name, x, y, steps, busy, done, underflow, load_ready,
                     ex, ey, es, eb, ed, eu, er);
        end
    endtask

    task automatic do_load(input logic [7:0] lx, input logic [7:0] ly);
        load_valid = 1'b1;
        load_x     = lx;
        load_y     = ly;
        tick();
        load_valid = 1'b0;
        load_x     = 8'd0;
        load_y     = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_x = 8'd0; load_y = 8'd0; selector = 1'b0;
        tick(); tick();
        rst = 1'b0;
        expect0("reset_values", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // selector in IDLE does nothing
        selector = 1'b1; tick(); selector = 1'b0;
        expect0("idle_selector_ignored", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("test_reset: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_exact_drain();
        selector = 1'b1;   // sampled during the load cycle: must have no effect
        do_load(8'd20, 8'd20);
        expect0("exact_load", 8'd20, 8'd20, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("exact_dec1", 8'd10, 8'd10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("exact_dec2", 8'd0, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("exact_done", 8'd0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        selector = 1'b0;
        tick(); expect0("exact_idle", 8'd0, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("test_exact_drain: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_residue();
        do_load(8'd30, 8'd20);
        selector = 1'b1;
        tick(); expect0("resid_dec1", 8'd20, 8'd10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("resid_dec2", 8'd10, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("resid_done", 8'd10, 8'd0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        selector = 1'b0;
        tick(); expect0("resid_idle_hold", 8'd10, 8'd0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); expect0("resid_idle_hold2", 8'd10, 8'd0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("test_residue: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_immediate_done();
        do_load(8'd25, 8'd5);
        expect0("imm_load_clears_uf", 8'd25, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        selector = 1'b1;
        tick(); expect0("imm_done", 8'd25, 8'd5, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        selector = 1'b0;
        tick(); expect0("imm_idle", 8'd25, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("test_immediate_done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_toggle_and_ignored_load();
        do_load(8'd40, 8'd40);
        selector = 1'b1;
        tick(); expect0("tog_dec1", 8'd30, 8'd30, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        selector = 1'b0; load_valid = 1'b1; load_x = 8'd99; load_y = 8'd7;
        tick(); expect0("tog_hold_load_ignored", 8'd30, 8'd30, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b0; load_x = 8'd0; load_y = 8'd0;
        tick(); expect0("tog_hold2", 8'd30, 8'd30, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        selector = 1'b1;
        tick(); expect0("tog_dec2", 8'd20, 8'd20, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("tog_dec3", 8'd10, 8'd10, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("tog_dec4", 8'd0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); expect0("tog_done", 8'd0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        selector = 1'b0;
        tick(); expect0("tog_idle", 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("test_toggle_and_ignored_load: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_op();
        do_load(8'd50, 8'd50);
        selector = 1'b1;
        tick(); tick();
        expect0("mid_before_rst", 8'd30, 8'd30, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); expect0("mid_after_rst", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; selector = 1'b0;
        tick(); expect0("mid_no_done", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // reset wins over a simultaneous load
        rst = 1'b1; load_valid = 1'b1; load_x = 8'd77; load_y = 8'd66;
        tick(); expect0("rst_beats_load", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; load_valid = 1'b0;
        do_load(8'd10, 8'd0);
        expect0("post_rst_load", 8'd10, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        selector = 1'b1;
        tick(); expect0("post_rst_done", 8'd10, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        selector = 1'b0;
        tick();
        $display("test_reset_mid_op: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_step1_saturate();
        int i;
        int bad;
        do_load(8'd255, 8'd255);
        checks++;
        if (x1 !== 8'd255 || y1 !== 8'd255 || busy1 !== 1'b1 || steps1 !== 8'd0) begin
            failures++;
            $display("FAIL s1_load: got x=%0d y=%0d busy=%b steps=%0d, want 255 255 1 0", x1, y1, busy1, steps1);
        end
        selector = 1'b1;
        bad = 0;
        for (i = 1; i <= 255; i++) begin
            tick();
            if (x1 !== 8'(255 - i) || y1 !== x1 || x2 !== x1 || done1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL s1_lockstep: got %0d bad cycles, want 0", bad);
        end
        checks++;
        if (x1 !== 8'd0 || y1 !== 8'd0 || steps1 !== 8'd255 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL s1_bottom: got x=%0d y=%0d steps=%0d busy=%b, want 0 0 255 1", x1, y1, steps1, busy1);
        end
        checks++;
        if (steps2 !== 4'd15 || x2 !== 8'd0) begin
            failures++;
            $display("FAIL s1_narrow_sat: got steps=%0d x=%0d, want 15 0", steps2, x2);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || underflow1 !== 1'b0 || busy1 !== 1'b0 || steps1 !== 8'd255) begin
            failures++;
            $display("FAIL s1_done: got done=%b uf=%b busy=%b steps=%0d, want 1 0 0 255", done1, underflow1, busy1, steps1);
        end
        selector = 1'b0;
        tick();
        checks++;
        if (done1 !== 1'b0 || load_ready1 !== 1'b1 || steps2 !== 4'd15) begin
            failures++;
            $display("FAIL s1_idle: got done=%b rdy=%b steps2=%0d, want 0 1 15", done1, load_ready1, steps2);
        end
        $display("test_step1_saturate: checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_exact_drain();
        test_residue();
        test_immediate_done();
        test_toggle_and_ignored_load();
        test_reset_mid_op();
        test_step1_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
